// File: rtl/wishbone_sram_bist_master.sv
// wishbone_sram_bist_master
//   Wishbone classic initiator that runs a write-then-readback self-test of an SRAM slave.
//   WORDS pseudo-random words (Galois LFSR) are written from base_adr_i with a 4-byte stride.
//   They are then read back and compared against the same LFSR sequence.
//   Mismatches are counted, and the address of the first failure is kept.
//   There is a single outstanding transfer and a 1-cycle idle gap after every ack.
//
// Optional feature: define WB_BIST_TIMEOUT_EN to abort the test when a slave fails to ack
// within TIMEOUT_CYCLES stalled cycles. Without it the initiator waits forever and
// timeout_o is tied to 0.
//
// Ports
//   wb_clk_i, wb_rst_i      clock, synchronous active-high reset
//   start_i                 1-cycle start pulse (ignored while busy_o)
//   base_adr_i, seed_i      test base byte address and LFSR seed, sampled on accepted start
//   wbm_*                   Wishbone classic initiator interface
//   busy_o, done_o, pass_o  test status
//   err_count_o             saturating read-mismatch count
//   fail_adr_o              address of first mismatch (0 if none)
//   timeout_o               ack timeout occurred
module wishbone_sram_bist_master #(
  parameter int unsigned WORDS          = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic [31:0] base_adr_i,
  input  logic [31:0] seed_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_count_o,
  output logic [31:0] fail_adr_o,
  output logic        timeout_o
);

  localparam int unsigned IdxW = $clog2(WORDS + 1);

  typedef enum logic [2:0] {StIdle, StWr, StWgap, StRd, StRgap, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [31:0]      seed_q, seed_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [15:0]      err_q, err_d;
  logic [31:0]      fail_q, fail_d;
  logic             done_q, done_d;
  logic             more_words;

`ifdef WB_BIST_TIMEOUT_EN
  localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmrW-1:0]  timer_q, timer_d;
  logic             timeout_q, timeout_d;
`endif

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? 32'h0040_0007 : 32'h0);
  endfunction

  assign more_words = 32'(idx_q) < WORDS;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    seed_d  = seed_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    err_d   = err_q;
    fail_d  = fail_q;
    done_d  = done_q;
`ifdef WB_BIST_TIMEOUT_EN
    timer_d   = timer_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          base_d  = base_adr_i;
          // An all-zero seed would lock the LFSR at zero.
          seed_d  = (seed_i == 32'h0) ? 32'h1 : seed_i;
          lfsr_d  = (seed_i == 32'h0) ? 32'h1 : seed_i;
          idx_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          done_d  = 1'b0;
          state_d = StWr;
`ifdef WB_BIST_TIMEOUT_EN
          timer_d   = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      StWr, StRd: begin
        if (wbm_ack_i) begin
          if (state_q == StRd && wbm_dat_i != lfsr_q) begin
            if (err_q == 16'h0) fail_d = wbm_adr_o;
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          end
          lfsr_d  = lfsr_next(lfsr_q);
          idx_d   = idx_q + 1'b1;
          state_d = (state_q == StWr) ? StWgap : StRgap;
`ifdef WB_BIST_TIMEOUT_EN
          timer_d = '0;
        end else if (32'(timer_q) >= TIMEOUT_CYCLES - 1) begin
          // This stalled cycle is the TIMEOUT_CYCLES-th one: release the bus now.
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StDone;
        end else begin
          timer_d = timer_q + 1'b1;
`endif
        end
      end
      StWgap: begin
        if (more_words) begin
          state_d = StWr;
        end else begin
          lfsr_d  = seed_q;
          idx_d   = '0;
          state_d = StRd;
        end
      end
      StRgap: begin
        if (more_words) begin
          state_d = StRd;
        end else begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      base_q  <= '0;
      seed_q  <= '0;
      lfsr_q  <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      done_q  <= 1'b0;
`ifdef WB_BIST_TIMEOUT_EN
      timer_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      seed_q  <= seed_d;
      lfsr_q  <= lfsr_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
`ifdef WB_BIST_TIMEOUT_EN
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign wbm_cyc_o   = (state_q == StWr) || (state_q == StRd);
  assign wbm_stb_o   = wbm_cyc_o;
  assign wbm_we_o    = (state_q == StWr);
  assign wbm_sel_o   = wbm_stb_o ? 4'hF : 4'h0;
  assign wbm_adr_o   = base_q + (32'(idx_q) << 2);
  assign wbm_dat_o   = lfsr_q;
  assign busy_o      = (state_q == StWr) || (state_q == StWgap) ||
                       (state_q == StRd) || (state_q == StRgap);
  assign done_o      = done_q;
  assign err_count_o = err_q;
  assign fail_adr_o  = fail_q;
`ifdef WB_BIST_TIMEOUT_EN
  assign timeout_o   = timeout_q;
`else
  assign timeout_o   = 1'b0;
`endif
  assign pass_o      = done_q && (err_q == 16'h0) && !timeout_o;

endmodule

// File: tb/tb_wishbone_sram_bist_master.sv
module tb_wishbone_sram_bist_master;
  localparam int unsigned Words         = 16;
  localparam int unsigned TimeoutCycles = 8;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] base, seed;
  logic        cyc, stb, we, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dato, rdat;
  logic        busy, done, pass, tmo;
  logic [15:0] errc;
  logic [31:0] fadr;

  wishbone_sram_bist_master #(.WORDS(Words), .TIMEOUT_CYCLES(TimeoutCycles)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .base_adr_i(base), .seed_i(seed),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel), .wbm_adr_o(adr),
    .wbm_dat_o(dato), .wbm_ack_i(ack), .wbm_dat_i(rdat), .busy_o(busy), .done_o(done),
    .pass_o(pass), .err_count_o(errc), .fail_adr_o(fadr), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // SRAM slave model: ws wait states per access, optional bit0 corruption on two addresses.
  int          ws        = 0;
  bit          never_ack = 1'b0;
  bit          flip_en   = 1'b0;
  int          wcnt      = 0;
  logic [31:0] mem [16];

  always_comb begin
    ack  = cyc & stb & ~never_ack & (wcnt == ws);
    rdat = mem[adr[5:2]];
    if (flip_en && (adr == 32'h8010 || adr == 32'h8020)) rdat[0] = ~rdat[0];
  end

  always @(posedge clk) begin
    if (cyc && stb && ack) begin
      wcnt <= 0;
      if (we) mem[adr[5:2]] <= dato;
    end else if (cyc && stb) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? 32'h0040_0007 : 32'h0);
  endfunction

  task automatic push_test(input logic [31:0] b, input logic [31:0] s);
    logic [31:0] l;
    l = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < Words; i++) begin
      exp_q.push_back({1'b1, b + 32'(4 * i), l});
      l = lfsr_next(l);
    end
    l = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < Words; i++) begin
      exp_q.push_back({1'b0, b + 32'(4 * i), l});
      l = lfsr_next(l);
    end
  endtask

  // Monitor: pops one expected transfer per acked strobe, checks hold-while-stalled and gaps.
  logic        prev_stall = 1'b0, prev_ack = 1'b0, p_we = 1'b0;
  logic [31:0] p_adr = '0, p_dat = '0;

  always @(negedge clk) begin
    xfer_t e;
    if (!rst) begin
      if (prev_stall && stb) begin
        check("adr_stable", adr, p_adr);
        check("dat_stable", dato, p_dat);
        check("we_stable", {31'h0, we}, {31'h0, p_we});
      end
      if (prev_ack) check("gap_after_ack", {31'h0, stb}, 32'h0);
      if (cyc && stb) check("sel", {28'h0, sel}, 32'hF);
      if (cyc && stb && ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {31'h0, we}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("xfer_we", {31'h0, we}, {31'h0, e.we});
          check("xfer_adr", adr, e.adr);
          if (e.we) check("xfer_wdat", dato, e.dat);
        end
      end
    end
    prev_stall <= cyc & stb & ~ack & ~rst;
    prev_ack   <= cyc & stb & ack & ~rst;
    p_adr      <= adr;
    p_dat      <= dato;
    p_we       <= we;
  end

  task automatic start_test(input logic [31:0] b, input logic [31:0] s, input bit do_push);
    @(posedge clk); #1;
    start = 1'b1;
    base  = b;
    seed  = s;
    if (do_push) push_test(b, s);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("first_stb", {31'h0, stb}, 32'h1);
    check("busy_on_start", {31'h0, busy}, 32'h1);
    check("done_cleared", {31'h0, done}, 32'h0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_within_budget", {31'h0, done}, 32'h1);
  endtask

  task automatic check_status(input logic [15:0] e_err, input logic [31:0] e_fail,
                              input logic e_pass);
    check("busy_at_done", {31'h0, busy}, 32'h0);
    check("pass", {31'h0, pass}, {31'h0, e_pass});
    check("err_count", {16'h0, errc}, {16'h0, e_err});
    check("fail_adr", fadr, e_fail);
    check("timeout", {31'h0, tmo}, 32'h0);
    check("cyc_idle_at_done", {31'h0, cyc}, 32'h0);
    check("queue_empty", exp_q.size(), 32'h0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    seed  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", {31'h0, cyc}, 32'h0);
    check("rst_stb", {31'h0, stb}, 32'h0);
    check("rst_sel", {28'h0, sel}, 32'h0);
    check("rst_status", {27'h0, busy, done, pass, tmo, |errc}, 32'h0);
    check("rst_fail_adr", fadr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: zero-wait, seed 1 -> write data 1<<i, all reads match
    start_test(32'h8000, 32'h1, 1'b1);
    check("seed1_first_dat", dato, 32'h1);
    wait_done(400);
    check_status(16'd0, 32'h0, 1'b1);

    // 2: two corrupted reads -> 2 errors, first at 0x8010
    flip_en = 1'b1;
    start_test(32'h8000, 32'h1, 1'b1);
    wait_done(400);
    check_status(16'd2, 32'h8010, 1'b0);
    flip_en = 1'b0;

    // 3: 3 wait states per ack, seed with bit31 set exercises the taps
    ws = 3;
    start_test(32'h8000, 32'h8000_0001, 1'b1);
    check("seed_msb_first_dat", dato, 32'h8000_0001);
    wait_done(800);
    check_status(16'd0, 32'h0, 1'b1);
    ws = 0;

    // 4: reset in write phase at i=5
    start_test(32'h8000, 32'h1234_5678, 1'b1);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 2 * Words - 5 && stb) break;
    end
    check("reached_word5", adr, 32'h8014);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_cyc_stb", {30'h0, cyc, stb}, 32'h0);
    check("midrst_status", {27'h0, busy, done, pass, tmo, |errc}, 32'h0);
    check("midrst_fail_adr", fadr, 32'h0);
    start_test(32'h8000, 32'h1, 1'b1);
    wait_done(400);
    check_status(16'd0, 32'h0, 1'b1);

    // 5: seed 0 behaves as seed 1; a start while busy changes nothing
    start_test(32'h8000, 32'h0, 1'b1);
    check("seed0_first_dat", dato, 32'h1);
    repeat (7) @(posedge clk);
    #1;
    start = 1'b1;
    base  = 32'h9000;
    seed  = 32'h5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(400);
    check_status(16'd0, 32'h0, 1'b1);

`ifdef WB_BIST_TIMEOUT_EN
    // 6: slave never acks -> strobe held for exactly TimeoutCycles cycles
    begin
      int stb_cycles = 1;
      never_ack = 1'b1;
      start_test(32'h8000, 32'h1, 1'b0);
      for (int k = 0; k < 50 && !done; k++) begin
        @(negedge clk);
        if (stb) stb_cycles++;
      end
      check("timeout_stb_cycles", stb_cycles, TimeoutCycles);
      check("timeout_flag", {31'h0, tmo}, 32'h1);
      check("timeout_pass", {31'h0, pass}, 32'h0);
      check("timeout_done", {31'h0, done}, 32'h1);
      check("timeout_cyc", {31'h0, cyc}, 32'h0);
      never_ack = 1'b0;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "time limit");
  end

endmodule
